// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the shared datapath (slave).
// Carries the instruction fields and status flags in, and every select/enable out.
interface multicycle_control_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             memReady;
   logic [3:0]       state;
   logic             pcWrite;
   logic             pcWriteCond;
   logic             irWrite;
   logic             memRead;
   logic             memWrite;
   logic             iorD;
   logic             regWrite;
   logic             regDst;
   logic             memToReg;
   logic             aluSrcA;
   logic [1:0]       aluSrcB;
   logic [2:0]       aluCtrl;
   logic [1:0]       pcSource;
   logic             illegal;
   logic [CNT_W-1:0] instRetired;

   modport master (
      input  opcode, funct, zero, memReady,
      output state, pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD,
             regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluCtrl, pcSource,
             illegal, instRetired
   );

   modport slave (
      output opcode, funct, zero, memReady,
      input  state, pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD,
             regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluCtrl, pcSource,
             illegal, instRetired
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: walks fetch/decode/execute/memory/writeback,
// decodes datapath controls from the state register, flags illegal ops, counts retirements.
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      IEXEC  = 4'd10,
      IWB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;

   state_t           r_state;
   logic             r_illegal;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       w_funct_alu;
   logic             w_funct_ok;
   logic             w_retire;

   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = ALU_ADD;
      case (bus.funct)
         6'b100000: w_funct_alu = ALU_ADD;
         6'b100010: w_funct_alu = ALU_SUB;
         6'b100100: w_funct_alu = ALU_AND;
         6'b100101: w_funct_alu = ALU_OR;
         6'b100110: w_funct_alu = ALU_XOR;
         default:   w_funct_ok  = 1'b0;
      endcase
   end

   // Retirement happens on the edge leaving the final state of each instruction.
   always_comb begin
      case (r_state)
         MEMWB, RWB, BRANCH, JUMP, IWB: w_retire = 1'b1;
         MEMWR:                         w_retire = bus.memReady;
         default:                       w_retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FETCH;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_retire) r_cnt <= r_cnt + 1'b1;
         case (r_state)
            FETCH:  if (bus.memReady) r_state <= DECODE;
            DECODE: begin
               case (bus.opcode)
                  OP_RTYPE:     r_state <= EXEC;
                  OP_LW, OP_SW: r_state <= MEMADR;
                  OP_BEQ:       r_state <= BRANCH;
                  OP_J:         r_state <= JUMP;
                  OP_ADDI:      r_state <= IEXEC;
                  default: begin
                     r_illegal <= 1'b1;
                     r_state   <= FETCH;
                  end
               endcase
            end
            MEMADR: r_state <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.memReady) r_state <= MEMWB;
            MEMWR:  if (bus.memReady) r_state <= FETCH;
            EXEC: begin
               if (w_funct_ok) begin
                  r_state <= RWB;
               end else begin
                  r_illegal <= 1'b1;
                  r_state   <= FETCH;
               end
            end
            IEXEC:   r_state <= IWB;
            default: r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      bus.pcWrite     = 1'b0;
      bus.pcWriteCond = 1'b0;
      bus.irWrite     = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
      bus.iorD        = 1'b0;
      bus.regWrite    = 1'b0;
      bus.regDst      = 1'b0;
      bus.memToReg    = 1'b0;
      bus.aluSrcA     = 1'b0;
      bus.aluSrcB     = 2'b00;
      bus.aluCtrl     = 3'b000;
      bus.pcSource    = 2'b00;
      case (r_state)
         FETCH: begin
            bus.memRead = 1'b1;
            bus.aluSrcB = 2'b01;
            bus.aluCtrl = ALU_ADD;
            bus.irWrite = bus.memReady;
            bus.pcWrite = bus.memReady;
         end
         DECODE: begin
            bus.aluSrcB = 2'b11;
            bus.aluCtrl = ALU_ADD;
         end
         MEMADR, IEXEC: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b10;
            bus.aluCtrl = ALU_ADD;
         end
         MEMRD: begin
            bus.memRead = 1'b1;
            bus.iorD    = 1'b1;
         end
         MEMWB: begin
            bus.regWrite = 1'b1;
            bus.memToReg = 1'b1;
         end
         MEMWR: begin
            bus.memWrite = 1'b1;
            bus.iorD     = 1'b1;
         end
         EXEC: begin
            bus.aluSrcA = 1'b1;
            bus.aluCtrl = w_funct_alu;
         end
         RWB: begin
            bus.regWrite = 1'b1;
            bus.regDst   = 1'b1;
         end
         BRANCH: begin
            bus.aluSrcA     = 1'b1;
            bus.aluCtrl     = ALU_SUB;
            bus.pcWriteCond = 1'b1;
            bus.pcSource    = 2'b01;
         end
         JUMP: begin
            bus.pcWrite  = 1'b1;
            bus.pcSource = 2'b10;
         end
         IWB:     bus.regWrite = 1'b1;
         default: ;
      endcase
   end

   assign bus.state       = r_state;
   assign bus.illegal     = r_illegal;
   assign bus.instRetired = r_cnt;
endmodule
